// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshakes, registered flags, iterative MUL/DIV
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake; op, a, b, shamt captured on acceptance
//   op [3:0]              0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 OR, 5 AND, 6 ADDN, 7 ADDZ, 8 MUL, 9 DIV
//   a, b [WIDTH-1:0]      operands
//   shamt [SHW-1:0]       shift amount for SLL/SRL
//   out_valid / out_ready response handshake; outputs held stable while out_valid && !out_ready
//   result                single-cycle op result
//   hi, lo                MUL high/low half, DIV remainder/quotient
//   zer, neg, car, ovf    registered status flags of the last completed op
//   dz                    last DIV had a zero divisor

module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zer,
    output logic             neg,
    output logic             car,
    output logic             ovf,
    output logic             dz
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nxt;

    // Iterative engine: work_hi/work_lo hold partial product (MUL) or
    // remainder/shifting dividend-quotient (DIV); opnd holds multiplicand or divisor.
    logic [WIDTH:0]   work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] opnd;
    logic [SHW-1:0]   iter;

    logic accept;
    logic last_iter;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (iter == SHW'(WIDTH - 1));

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op == 4'd8)      state_nxt = S_MUL;
                    else if (op == 4'd9) state_nxt = S_DIV;
                    else                 state_nxt = S_DONE;
                end
            end
            S_MUL, S_DIV: if (last_iter) state_nxt = S_DONE;
            S_DONE:       if (out_ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Single-cycle ops
    // ---------------------------------------------------------------
    logic [WIDTH:0]   sum, diff, sll_full;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_car, alu_ovf;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        // Bit WIDTH of the widened shift is the last bit pushed out (0 when shamt=0).
        sll_full = {1'b0, a} << shamt;
        add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

        alu_res = '0;
        alu_car = 1'b0;
        alu_ovf = 1'b0;
        case (op)
            4'd0: begin alu_res = sum[WIDTH-1:0];  alu_car = sum[WIDTH];   alu_ovf = add_ovf; end
            4'd1: begin alu_res = diff[WIDTH-1:0]; alu_car = ~diff[WIDTH]; alu_ovf = sub_ovf; end
            4'd2: begin alu_res = sll_full[WIDTH-1:0]; alu_car = sll_full[WIDTH]; end
            4'd3: alu_res = a >> shamt;
            4'd4: alu_res = a | b;
            4'd5: alu_res = a & b;
            4'd6: begin
                if (neg) begin alu_res = sum[WIDTH-1:0]; alu_car = sum[WIDTH]; alu_ovf = add_ovf; end
                else     alu_res = a;
            end
            4'd7: begin
                if (zer) begin alu_res = sum[WIDTH-1:0]; alu_car = sum[WIDTH]; alu_ovf = add_ovf; end
                else     alu_res = a;
            end
            default: alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // One MUL / DIV iteration
    // ---------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_sub;
    logic             div_ge;
    logic [WIDTH:0]   it_hi;
    logic [WIDTH-1:0] it_lo;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the {partial, multiplier} pair right by one.
        mul_sum   = work_hi + (work_lo[0] ? {1'b0, opnd} : '0);
        // Restoring divide: shift the next dividend bit into the remainder and
        // subtract the divisor when it fits. A zero divisor always "fits",
        // which yields quotient all ones and remainder = dividend.
        div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        div_sub   = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});

        if (state == S_DIV) begin
            it_hi = div_ge ? div_sub : div_shift;
            it_lo = {work_lo[WIDTH-2:0], div_ge};
        end else begin
            it_hi = {1'b0, mul_sum[WIDTH:1]};
            it_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end
    end

    // ---------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            hi      <= '0;
            lo      <= '0;
            zer     <= 1'b0;
            neg     <= 1'b0;
            car     <= 1'b0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            work_hi <= '0;
            work_lo <= '0;
            opnd    <= '0;
            iter    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        iter    <= '0;
                        work_hi <= '0;
                        if (op == 4'd8) begin
                            work_lo <= b;
                            opnd    <= a;
                        end else if (op == 4'd9) begin
                            work_lo <= a;
                            opnd    <= b;
                        end else if (op <= 4'd7) begin
                            result <= alu_res;
                            zer    <= (alu_res == '0);
                            neg    <= alu_res[WIDTH-1];
                            car    <= alu_car;
                            ovf    <= alu_ovf;
                            dz     <= 1'b0;
                        end else begin
                            // Unknown opcode: zero result, flags and hi/lo kept.
                            result <= '0;
                            dz     <= 1'b0;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    work_hi <= it_hi;
                    work_lo <= it_lo;
                    iter    <= iter + 1'b1;
                    if (last_iter) begin
                        hi  <= it_hi[WIDTH-1:0];
                        lo  <= it_lo;
                        zer <= (it_hi[WIDTH-1:0] == '0) && (it_lo == '0);
                        neg <= it_hi[WIDTH-1];
                        car <= 1'b0;
                        ovf <= 1'b0;
                        dz  <= (state == S_DIV) && (opnd == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against an arithmetic model

module tb_alu_mc;

    localparam int W    = 16;
    localparam int SHW  = $clog2(W);
    localparam int MASK = (1 << W) - 1;
    localparam int SMIN = -(1 << (W - 1));
    localparam int SMAX = (1 << (W - 1)) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SHW-1:0] shamt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           zer, neg, car, ovf, dz;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .lo(lo),
        .zer(zer), .neg(neg), .car(car), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_result, m_hi, m_lo;
    bit m_zer, m_neg, m_car, m_ovf, m_dz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_result = 0; m_hi = 0; m_lo = 0;
        m_zer = 0; m_neg = 0; m_car = 0; m_ovf = 0; m_dz = 0;
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    task automatic set_single(input int r, input bit c, input bit o);
        m_result = r;
        m_zer    = (r == 0);
        m_neg    = ((r >> (W - 1)) & 1) != 0;
        m_car    = c;
        m_ovf    = o;
        m_dz     = 0;
    endtask

    task automatic model_add(input int av, input int bv);
        int s, ss;
        s  = av + bv;
        ss = sx(av) + sx(bv);
        set_single(s & MASK, ((s >> W) & 1) != 0, (ss > SMAX) || (ss < SMIN));
    endtask

    task automatic model_op(input int opv, input int av, input int bv, input int sh);
        int     ss, full;
        longint p;
        case (opv)
            0: model_add(av, bv);
            1: begin
                ss = sx(av) - sx(bv);
                set_single((av - bv) & MASK, av >= bv, (ss > SMAX) || (ss < SMIN));
            end
            2: begin
                full = av << sh;
                set_single(full & MASK, (sh != 0) && (((full >> W) & 1) != 0), 0);
            end
            3: set_single(av >> sh, 0, 0);
            4: set_single(av | bv, 0, 0);
            5: set_single(av & bv, 0, 0);
            6: if (m_neg) model_add(av, bv); else set_single(av, 0, 0);
            7: if (m_zer) model_add(av, bv); else set_single(av, 0, 0);
            8: begin
                p     = longint'(av) * longint'(bv);
                m_hi  = int'(p >> W);
                m_lo  = int'(p & MASK);
                m_zer = (p == 0);
                m_neg = ((m_hi >> (W - 1)) & 1) != 0;
                m_car = 0; m_ovf = 0; m_dz = 0;
            end
            9: begin
                if (bv == 0) begin
                    m_lo = MASK; m_hi = av; m_dz = 1;
                end else begin
                    m_lo = av / bv; m_hi = av % bv; m_dz = 0;
                end
                m_zer = (m_hi == 0) && (m_lo == 0);
                m_neg = ((m_hi >> (W - 1)) & 1) != 0;
                m_car = 0; m_ovf = 0;
            end
            default: begin
                m_result = 0;
                m_dz     = 0;
            end
        endcase
    endtask

    task automatic check_outputs(input int opv);
        if (opv != 8 && opv != 9) check("result", 64'(result), 64'(m_result));
        check("hi",  64'(hi),  64'(m_hi));
        check("lo",  64'(lo),  64'(m_lo));
        check("zer", 64'(zer), 64'(m_zer));
        check("neg", 64'(neg), 64'(m_neg));
        check("car", 64'(car), 64'(m_car));
        check("ovf", 64'(ovf), 64'(m_ovf));
        if (opv <= 9) check("dz", 64'(dz), 64'(m_dz));
    endtask

    task automatic run_op(input int opv, input int av, input int bv, input int sh, input int hold);
        int lat, exp_lat;
        exp_lat = (opv == 8 || opv == 9) ? W + 1 : 1;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        op = opv[3:0]; a = av[W-1:0]; b = bv[W-1:0]; shamt = sh[SHW-1:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        model_op(opv, av & MASK, bv & MASK, sh);
        check("latency", 64'(lat), 64'(exp_lat));
        check_outputs(opv);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_pop", 64'(out_valid), 64'd0);
        check("in_ready_after_pop", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int opv, av, bv, sh;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; shamt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({zer, neg, car, ovf, dz}), 64'd0);

        // Signed overflow on ADD
        run_op(0, 16'h7FFF, 16'h0001, 0, 0);
        check("tp1_result", 64'(result), 64'h8000);
        check("tp1_flags", 64'({zer, neg, car, ovf}), 64'b0101);

        // SUB to zero, then ADDZ taken from the stored zer flag
        run_op(1, 5, 5, 0, 1);
        check("tp2_sub_flags", 64'({zer, car}), 64'b11);
        run_op(7, 16'h0010, 16'h0003, 0, 0);
        check("tp2_addz", 64'(result), 64'h0013);

        // MUL
        run_op(8, 16'h1234, 16'h0010, 0, 0);
        check("tp3_hi", 64'(hi), 64'h0001);
        check("tp3_lo", 64'(lo), 64'h2340);
        run_op(8, 16'hFFFF, 16'hFFFF, 0, 2);
        check("tp3_hi_max", 64'(hi), 64'hFFFE);
        check("tp3_lo_max", 64'(lo), 64'h0001);

        // DIV, including divide by zero
        run_op(9, 100, 7, 0, 0);
        check("tp4_div", 64'({hi, lo, 15'd0, dz}), 64'({16'd2, 16'd14, 16'd0}));
        run_op(9, 16'h00AB, 0, 0, 0);
        check("tp4_dz", 64'({hi, lo, 15'd0, dz}), 64'({16'h00AB, 16'hFFFF, 16'd1}));

        // Backpressure: outputs stable, no second acceptance while stalled
        @(negedge clk);
        op = 4'd0; a = 16'h1111; b = 16'h2222; shamt = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        model_op(0, 16'h1111, 16'h2222, 0);
        op = 4'd1; a = 16'h0F0F; b = 16'h0001;
        check("bp_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result", 64'(result), 64'(m_result));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_out_valid_after", 64'(out_valid), 64'd0);

        // Reset in the middle of a MUL
        @(negedge clk);
        op = 4'd8; a = 16'hBEEF; b = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("mr_in_ready", 64'(in_ready), 64'd1);
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_outputs", 64'({result, hi, lo}), 64'd0);
        check("mr_flags", 64'({zer, neg, car, ovf, dz}), 64'd0);
        run_op(0, 2, 3, 0, 0);
        check("mr_add", 64'(result), 64'd5);

        // Randomized operations
        for (int n = 0; n < 160; n++) begin
            opv = (($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                : int'($urandom_range(0, 9)));
            av  = int'($urandom_range(0, MASK));
            case ($urandom_range(0, 7))
                0:       bv = 0;
                1:       bv = av;
                2:       bv = int'($urandom_range(1, 15));
                default: bv = int'($urandom_range(0, MASK));
            endcase
            sh = int'($urandom_range(0, W - 1));
            run_op(opv, av, bv, sh, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
